// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: datapath widths, ALU op
// encodings and sequencer states.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decode-side request/load ports, the ALU drive/capture port
// and the status outputs of the ALU issue sequencer.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = DATA_W
);

    // Handshakes: a request or load transfers on a rising clk edge where both
    // its valid and its ready are high; the requester holds valid and payload
    // stable until then, and ready never depends on payload contents.
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_rn;
    logic [AW-1:0] in_rm;
    logic [AW-1:0] in_rd;
    logic          in_wb;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_reg;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] val_A;
    logic [DW-1:0] val_B;
    logic [1:0]    ALU_op;
    logic [DW-1:0] ALU_out;
    logic          Z;

    logic [DW-1:0] result;
    logic          status_Z;
    logic          done;

    modport slave (
        input  in_valid, in_op, in_rn, in_rm, in_rd, in_wb,
        input  ld_valid, ld_reg, ld_data,
        input  ALU_out, Z,
        output in_ready, ld_ready,
        output val_A, val_B, ALU_op,
        output result, status_Z, done
    );

    modport master (
        output in_valid, in_op, in_rn, in_rm, in_rd, in_wb,
        output ld_valid, ld_reg, ld_data,
        output ALU_out, Z,
        input  in_ready, ld_ready,
        input  val_A, val_B, ALU_op,
        input  result, status_Z, done
    );

endinterface

// File: rtl/alu_regfile.sv
// General register file: one synchronous write port, two combinational read
// ports, synchronous active-low clear of every entry.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N_ENTRIES = NREGS,
    parameter int WIDTH     = DATA_W,
    parameter int AW        = $clog2(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddrA,
    input  logic [AW-1:0]    rdAddrB,
    output logic [WIDTH-1:0] rdDataA,
    output logic [WIDTH-1:0] rdDataB
);

    logic [WIDTH-1:0] regs [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-phase sequencer (IDLE/READ/EXEC/WRITE) that feeds the external 16-bit
// ALU from the register file, captures its result and optionally writes back.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    alu_issue_ctrl_if.slave        bus,
    output state_e                 stateDbg
);

    state_e              state;
    aluOp_e              opL;
    logic [REG_AW-1:0]   rnL;
    logic [REG_AW-1:0]   rmL;
    logic [REG_AW-1:0]   rdL;
    logic                wbL;
    logic [DATA_W-1:0]   regA;
    logic [DATA_W-1:0]   regB;
    logic [DATA_W-1:0]   regC;
    logic                statusZ;

    logic                isIdle;
    logic                accept;
    logic                rfWrEn;
    logic [REG_AW-1:0]   rfWrAddr;
    logic [DATA_W-1:0]   rfWrData;
    logic [DATA_W-1:0]   rfRdA;
    logic [DATA_W-1:0]   rfRdB;

    assign isIdle       = (state == S_IDLE);
    assign bus.ld_ready = isIdle;
    // A pending load steals the IDLE cycle from the operation request.
    assign bus.in_ready = isIdle & ~bus.ld_valid;
    assign accept       = bus.in_valid & bus.in_ready;

    // Loads only happen in IDLE and writeback only in WRITE, so one port suffices.
    always_comb begin
        rfWrEn   = 1'b0;
        rfWrAddr = bus.ld_reg;
        rfWrData = bus.ld_data;
        if (isIdle && bus.ld_valid) begin
            rfWrEn = 1'b1;
        end else if (state == S_WRITE && wbL) begin
            rfWrEn   = 1'b1;
            rfWrAddr = rdL;
            rfWrData = regC;
        end
    end

    alu_regfile #(
        .N_ENTRIES (NREGS),
        .WIDTH     (DATA_W),
        .AW        (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .wrEn    (rfWrEn),
        .wrAddr  (rfWrAddr),
        .wrData  (rfWrData),
        .rdAddrA (rnL),
        .rdAddrB (rmL),
        .rdDataA (rfRdA),
        .rdDataB (rfRdB)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            opL     <= ALU_ADD;
            rnL     <= '0;
            rmL     <= '0;
            rdL     <= '0;
            wbL     <= 1'b0;
            regA    <= '0;
            regB    <= '0;
            regC    <= '0;
            statusZ <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opL   <= aluOp_e'(bus.in_op);
                        rnL   <= bus.in_rn;
                        rmL   <= bus.in_rm;
                        rdL   <= bus.in_rd;
                        wbL   <= bus.in_wb;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    regA  <= rfRdA;
                    regB  <= rfRdB;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    regC    <= bus.ALU_out;
                    statusZ <= bus.Z;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU inputs come straight from the operand registers, so they hold between ops.
    assign bus.val_A    = regA;
    assign bus.val_B    = regB;
    assign bus.ALU_op   = opL;
    assign bus.result   = regC;
    assign bus.status_Z = statusZ;
    assign bus.done     = (state == S_WRITE);
    assign stateDbg     = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: acts as decode and as the external
// ALU, and checks against a register-array reference model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();
    state_e stateDbg;

    alu_issue_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .stateDbg (stateDbg)
    );

    // External ALU stand-in.
    always_comb begin
        case (bus.ALU_op)
            2'b00:   bus.ALU_out = bus.val_A + bus.val_B;
            2'b01:   bus.ALU_out = bus.val_A - bus.val_B;
            2'b10:   bus.ALU_out = bus.val_A & bus.val_B;
            default: bus.ALU_out = ~bus.val_A;
        endcase
    end
    assign bus.Z = (bus.ALU_out == '0);

    // ---------------- reference model / scoreboard ----------------
    int testCount = 0;
    int failCount = 0;
    int rfModel [NREGS];
    logic [DATA_W-1:0] expQ [$];

    function automatic int refAlu(input logic [1:0] op, input int a, input int b);
        case (op)
            2'b00:   return (a + b) % 65536;
            2'b01:   return (a - b + 65536) % 65536;
            2'b10:   return a & b;
            default: return 65535 - a;
        endcase
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Every task starts and ends 1ns after a rising edge.
    task automatic idleInputs();
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rn    = '0;
        bus.in_rm    = '0;
        bus.in_rd    = '0;
        bus.in_wb    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_reg   = '0;
        bus.ld_data  = '0;
    endtask

    task automatic doLoad(input int r, input int d);
        int w;
        bus.ld_valid = 1'b1;
        bus.ld_reg   = REG_AW'(r);
        bus.ld_data  = DATA_W'(d);
        w = 0;
        @(negedge clk);
        while (!bus.ld_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ld_ready) checkEq("ld_timeout", 32'd0, 32'd1);
        else rfModel[r] = d % 65536;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
    endtask

    task automatic doOp(input string tag, input logic [1:0] op, input int rn, input int rm,
                        input int rd, input bit wb, input bit holdValid, output int acceptWait);
        int w;
        int k;
        int a;
        int b;
        int expRes;
        logic [DATA_W-1:0] expPop;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rn    = REG_AW'(rn);
        bus.in_rm    = REG_AW'(rm);
        bus.in_rd    = REG_AW'(rd);
        bus.in_wb    = wb;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        acceptWait = w;
        if (!bus.in_ready) begin
            checkEq({tag, "_accept_timeout"}, 32'd0, 32'd1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            return;
        end
        a = rfModel[rn];
        b = rfModel[rm];
        expRes = refAlu(op, a, b);
        expQ.push_back(DATA_W'(expRes));
        @(posedge clk);
        #1;
        if (!holdValid) bus.in_valid = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.done) break;
            checkEq({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
            if (k == 2) begin
                checkEq({tag, "_exec_op"}, 32'(bus.ALU_op), 32'(op));
                checkEq({tag, "_exec_A"}, 32'(bus.val_A), 32'(a));
                checkEq({tag, "_exec_B"}, 32'(bus.val_B), 32'(b));
            end
        end
        checkEq({tag, "_latency"}, 32'(k), 32'd3);
        checkEq({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
        if (expQ.size() > 0) begin
            expPop = expQ.pop_front();
            checkEq({tag, "_result"}, 32'(bus.result), 32'(expPop));
            checkEq({tag, "_status_Z"}, 32'(bus.status_Z), 32'(expPop == '0));
        end
        if (wb) rfModel[rd] = expRes;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        checkEq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        checkEq({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Reads a register back through the ALU: AND r,r without writeback yields rf[r].
    task automatic checkReg(input string tag, input int r);
        int w;
        doOp(tag, 2'b10, r, r, 0, 1'b0, 1'b0, w);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int doneSeen;
        idleInputs();
        for (int i = 0; i < NREGS; i++) rfModel[i] = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        checkEq("rst_state", 32'(stateDbg), 32'(S_IDLE));
        checkEq("rst_result", 32'(bus.result), 32'd0);
        checkEq("rst_status_Z", 32'(bus.status_Z), 32'd0);
        checkEq("rst_done", 32'(bus.done), 32'd0);
        checkEq("rst_val_A", 32'(bus.val_A), 32'd0);
        checkEq("rst_val_B", 32'(bus.val_B), 32'd0);
        checkEq("rst_ALU_op", 32'(bus.ALU_op), 32'd0);
        checkEq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkEq("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed sequence.
        doLoad(1, 13);
        doLoad(2, 4);
        doOp("add", ALU_ADD, 1, 2, 3, 1'b1, 1'b0, w);
        checkReg("r3_after_add", 3);
        doOp("sub_cmp", ALU_SUB, 1, 2, 3, 1'b0, 1'b0, w);
        checkReg("r3_after_cmp", 3);
        doLoad(4, 10);
        doLoad(5, 11);
        doOp("and", ALU_AND, 4, 5, 6, 1'b1, 1'b0, w);
        doOp("not_r0", ALU_NOT, 0, 2, 7, 1'b0, 1'b0, w);
        doOp("sub_zero", ALU_SUB, 1, 1, 0, 1'b0, 1'b0, w);
        doOp("add_nz", ALU_ADD, 4, 5, 0, 1'b0, 1'b0, w);

        // Load and request together: the load wins, the op goes next cycle.
        bus.ld_valid = 1'b1;
        bus.ld_reg   = 3'd5;
        bus.ld_data  = 16'd77;
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rn    = 3'd5;
        bus.in_rm    = 3'd4;
        bus.in_rd    = 3'd6;
        bus.in_wb    = 1'b1;
        @(negedge clk);
        checkEq("coll_in_ready", 32'(bus.in_ready), 32'd0);
        checkEq("coll_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        rfModel[5] = 77;
        doOp("coll_op", ALU_ADD, 5, 4, 6, 1'b1, 1'b1, w);
        checkEq("coll_accept_wait", 32'(w), 32'd0);
        doOp("hold_valid", ALU_SUB, 6, 2, 1, 1'b1, 1'b1, w);
        checkReg("r6_after_coll", 6);

        // Randomized phase.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) doLoad($urandom_range(0, NREGS - 1), $urandom_range(0, 3));
                else doLoad($urandom_range(0, NREGS - 1), $urandom_range(0, 65535));
            end else begin
                doOp("rand", 2'($urandom_range(0, 3)), $urandom_range(0, NREGS - 1),
                     $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            end
            if (n % 15 == 14) checkReg("rand_readback", $urandom_range(0, NREGS - 1));
        end

        // Reset during EXEC of a writeback op abandons it.
        doLoad(1, 13);
        doLoad(2, 4);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rn    = 3'd1;
        bus.in_rm    = 3'd2;
        bus.in_rd    = 3'd7;
        bus.in_wb    = 1'b1;
        @(negedge clk);
        checkEq("mid_rst_pre_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkEq("mid_rst_in_exec", 32'(stateDbg), 32'(S_EXEC));
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) rfModel[i] = 0;
        expQ.delete();
        @(negedge clk);
        checkEq("mid_rst_state", 32'(stateDbg), 32'(S_IDLE));
        checkEq("mid_rst_result", 32'(bus.result), 32'd0);
        checkEq("mid_rst_status_Z", 32'(bus.status_Z), 32'd0);
        checkEq("mid_rst_val_A", 32'(bus.val_A), 32'd0);
        checkEq("mid_rst_val_B", 32'(bus.val_B), 32'd0);
        checkEq("mid_rst_ALU_op", 32'(bus.ALU_op), 32'd0);
        doneSeen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done) doneSeen++;
            @(negedge clk);
        end
        checkEq("mid_rst_no_done", 32'(doneSeen), 32'd0);
        @(posedge clk);
        #1;
        checkReg("mid_rst_r7", 7);
        checkReg("mid_rst_r1", 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
